// File: rtl/vic_regs.sv
// VIC-I register file ($9000-$900F) with raster line counter and derived video-control outputs.
// Single-cycle: writes take effect at the edge; reads load dout at the edge; no backpressure.
module vic_regs #(
  parameter logic [7:0] R0_INIT  = 8'h05,
  parameter logic [7:0] R1_INIT  = 8'h19,
  parameter logic [7:0] R2_INIT  = 8'h96,
  parameter logic [7:0] R3_INIT  = 8'hAE,
  parameter logic [7:0] R5_INIT  = 8'hF0,
  parameter logic [7:0] RF_INIT  = 8'h1B,
  parameter int         LINE_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        line_strobe,
  input  logic        frame_strobe,
  input  logic [7:0]  pot_x,
  input  logic [7:0]  pot_y,
  input  logic [7:0]  lp_x,
  input  logic [7:0]  lp_y,
  output logic [15:0] screen_addr,
  output logic [15:0] char_rom_addr,
  output logic [15:0] color_ram_addr,
  output logic [6:0]  xorigin,
  output logic [6:0]  yorigin,
  output logic [6:0]  rows,
  output logic [6:0]  cols,
  output logic [2:0]  border_color,
  output logic [3:0]  back_color,
  output logic [3:0]  aux_color,
  output logic        inverted,
  output logic        chars8x16,
  output logic        interlace
);

  localparam logic [1:0] DIV_LAST = 2'(LINE_DIV - 1);

  logic [7:0]  r0, r1, r2, r5, ra, rb, rc, rd, re, rf;
  logic [6:0]  r3;
  logic [8:0]  raster;
  logic [1:0]  div_cnt;
  logic [7:0]  rd_dat;
  logic [13:0] screen_v;
  logic [13:0] char_v;

  always_comb begin
    rd_dat = 8'h00;
    case (addr)
      4'h0: rd_dat = r0;
      4'h1: rd_dat = r1;
      4'h2: rd_dat = r2;
      4'h3: rd_dat = {raster[0], r3};
      4'h4: rd_dat = raster[8:1];
      4'h5: rd_dat = r5;
      4'h6: rd_dat = lp_x;
      4'h7: rd_dat = lp_y;
      4'h8: rd_dat = pot_x;
      4'h9: rd_dat = pot_y;
      4'hA: rd_dat = ra;
      4'hB: rd_dat = rb;
      4'hC: rd_dat = rc;
      4'hD: rd_dat = rd;
      4'hE: rd_dat = re;
      4'hF: rd_dat = rf;
      default: rd_dat = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r0      <= R0_INIT;
      r1      <= R1_INIT;
      r2      <= R2_INIT;
      r3      <= R3_INIT[6:0];
      r5      <= R5_INIT;
      ra      <= 8'h00;
      rb      <= 8'h00;
      rc      <= 8'h00;
      rd      <= 8'h00;
      re      <= 8'h00;
      rf      <= RF_INIT;
      raster  <= 9'd0;
      div_cnt <= 2'd0;
      dout    <= 8'h00;
    end else begin
      if (cs && we) begin
        case (addr)
          4'h0: r0 <= din;
          4'h1: r1 <= din;
          4'h2: r2 <= din;
          4'h3: r3 <= din[6:0];
          4'h5: r5 <= din;
          4'hA: ra <= din;
          4'hB: rb <= din;
          4'hC: rc <= din;
          4'hD: rd <= din;
          4'hE: re <= din;
          4'hF: rf <= din;
          default: ;
        endcase
      end
      if (cs && !we)
        dout <= rd_dat;
      // Frame start resets the line count even if a line strobe lands on the same cycle.
      if (frame_strobe) begin
        raster  <= 9'd0;
        div_cnt <= 2'd0;
      end else if (line_strobe) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= 2'd0;
          raster  <= raster + 9'd1;
        end else begin
          div_cnt <= div_cnt + 2'd1;
        end
      end
    end
  end

  // VIC address bit 13 is inverted onto CPU A15; A14/A13 are always zero.
  assign screen_v       = {r5[7:4], r2[7], 9'b0};
  assign char_v         = {r5[3:0], 10'b0};
  assign screen_addr    = {~screen_v[13], 2'b00, screen_v[12:0]};
  assign char_rom_addr  = {~char_v[13], 2'b00, char_v[12:0]};
  assign color_ram_addr = 16'h9400 | {6'b0, r2[7], 9'b0};

  assign xorigin      = r0[6:0];
  assign yorigin      = r1[7:1];
  assign cols         = r2[6:0];
  assign rows         = {1'b0, r3[6:1]};
  assign border_color = rf[2:0];
  assign back_color   = rf[7:4];
  assign aux_color    = re[7:4];
  assign inverted     = ~rf[3];
  assign chars8x16    = r3[0];
  assign interlace    = r0[7];

endmodule

// File: tb/tb_vic_regs.sv
// Directed bench for vic_regs: reset values, address derivation, raster counting/wrap, ignored writes, colours.
module tb_vic_regs;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0, we = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        line_strobe = 1'b0, frame_strobe = 1'b0;
  logic [7:0]  pot_x = 8'h5A, pot_y = 8'hA5, lp_x = 8'h3C, lp_y = 8'hC3;
  logic [15:0] screen_addr, char_rom_addr, color_ram_addr;
  logic [6:0]  xorigin, yorigin, rows, cols;
  logic [2:0]  border_color;
  logic [3:0]  back_color, aux_color;
  logic        inverted, chars8x16, interlace;

  int vectors = 0;
  int errs = 0;

  vic_regs dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .din(din), .dout(dout),
    .line_strobe(line_strobe), .frame_strobe(frame_strobe),
    .pot_x(pot_x), .pot_y(pot_y), .lp_x(lp_x), .lp_y(lp_y),
    .screen_addr(screen_addr), .char_rom_addr(char_rom_addr), .color_ram_addr(color_ram_addr),
    .xorigin(xorigin), .yorigin(yorigin), .rows(rows), .cols(cols),
    .border_color(border_color), .back_color(back_color), .aux_color(aux_color),
    .inverted(inverted), .chars8x16(chars8x16), .interlace(interlace)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); cs = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clk); cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk); cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk); cs = 1'b0; d = dout;
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); line_strobe = 1'b1;
      @(negedge clk); line_strobe = 1'b0;
    end
  endtask

  task automatic frame;
    @(negedge clk); frame_strobe = 1'b1;
    @(negedge clk); frame_strobe = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    lines(5);
    wr(4'h0, 8'h7F);
    rd(4'h0, v);
    // Abort a write to RF by asserting reset while it is in flight.
    @(negedge clk); cs = 1'b1; we = 1'b1; addr = 4'hF; din = 8'hFF;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); cs = 1'b0; we = 1'b0; reset = 1'b1;
    vectors++; if (dout !== 8'h00) begin errs++; $display("FAIL reset_dout got=%h exp=00", dout); end
    vectors++; if (screen_addr !== 16'h1E00) begin errs++; $display("FAIL reset_screen got=%h exp=1e00", screen_addr); end
    vectors++; if (char_rom_addr !== 16'h8000) begin errs++; $display("FAIL reset_char got=%h exp=8000", char_rom_addr); end
    vectors++; if (color_ram_addr !== 16'h9600) begin errs++; $display("FAIL reset_color got=%h exp=9600", color_ram_addr); end
    vectors++; if ({border_color, back_color, inverted, chars8x16, interlace} !== {3'd3, 4'd1, 1'b0, 1'b0, 1'b0})
      begin errs++; $display("FAIL reset_flags got=%h/%h/%b%b%b exp=3/1/000", border_color, back_color, inverted, chars8x16, interlace); end
    vectors++; if ({xorigin, yorigin, cols, rows} !== {7'd5, 7'd12, 7'd22, 7'd23})
      begin errs++; $display("FAIL reset_geom got=%0d/%0d/%0d/%0d exp=5/12/22/23", xorigin, yorigin, cols, rows); end
    vectors++; if (aux_color !== 4'd0) begin errs++; $display("FAIL reset_aux got=%h exp=0", aux_color); end
    rd(4'h4, v);
    vectors++; if (v !== 8'h00) begin errs++; $display("FAIL reset_reg4 got=%h exp=00", v); end
    rd(4'h3, v);
    vectors++; if (v !== 8'h2E) begin errs++; $display("FAIL reset_reg3 got=%h exp=2e", v); end
    rd(4'hF, v);
    vectors++; if (v !== 8'h1B) begin errs++; $display("FAIL reset_abort_rf got=%h exp=1b", v); end
  endtask

  task automatic test_addr;
    wr(4'h5, 8'hCD);
    wr(4'h2, 8'h16);
    // VIC $3000 -> CPU $1000; VIC $3400 -> CPU $1400; A9 clear -> colour at $9400.
    vectors++; if (screen_addr !== 16'h1000) begin errs++; $display("FAIL addr_screen got=%h exp=1000", screen_addr); end
    vectors++; if (char_rom_addr !== 16'h1400) begin errs++; $display("FAIL addr_char got=%h exp=1400", char_rom_addr); end
    vectors++; if (color_ram_addr !== 16'h9400) begin errs++; $display("FAIL addr_color got=%h exp=9400", color_ram_addr); end
    vectors++; if (cols !== 7'd22) begin errs++; $display("FAIL addr_cols got=%0d exp=22", cols); end
    wr(4'h5, 8'h02);
    wr(4'h2, 8'h80);
    // VIC $0200 -> $8200 screen; char VIC $0800 -> $8800.
    vectors++; if ({screen_addr, char_rom_addr, color_ram_addr} !== {16'h8200, 16'h8800, 16'h9600})
      begin errs++; $display("FAIL addr_low got=%h/%h/%h exp=8200/8800/9600", screen_addr, char_rom_addr, color_ram_addr); end
  endtask

  task automatic test_raster;
    logic [7:0] v;
    frame();
    lines(7);
    rd(4'h3, v);
    vectors++; if (v !== 8'hAE) begin errs++; $display("FAIL raster_reg3 got=%h exp=ae", v); end
    rd(4'h4, v);
    vectors++; if (v !== 8'h01) begin errs++; $display("FAIL raster_reg4 got=%h exp=01", v); end
    @(negedge clk); frame_strobe = 1'b1; line_strobe = 1'b1;
    @(negedge clk); frame_strobe = 1'b0; line_strobe = 1'b0;
    rd(4'h4, v);
    vectors++; if (v !== 8'h00) begin errs++; $display("FAIL raster_frame_reg4 got=%h exp=00", v); end
    rd(4'h3, v);
    vectors++; if (v !== 8'h2E) begin errs++; $display("FAIL raster_frame_reg3 got=%h exp=2e", v); end
    lines(2);
    rd(4'h3, v);
    vectors++; if (v !== 8'hAE) begin errs++; $display("FAIL raster_div_clear got=%h exp=ae", v); end
    // Read issued on the incrementing edge sees the old count.
    @(negedge clk); line_strobe = 1'b1; cs = 1'b1; we = 1'b0; addr = 4'h3;
    @(negedge clk); line_strobe = 1'b0; cs = 1'b0;
    @(negedge clk); line_strobe = 1'b1; cs = 1'b1; addr = 4'h3;
    @(negedge clk); line_strobe = 1'b0; cs = 1'b0;
    vectors++; if (dout !== 8'hAE) begin errs++; $display("FAIL raster_pre_inc got=%h exp=ae", dout); end
    rd(4'h3, v);
    vectors++; if (v !== 8'h2E) begin errs++; $display("FAIL raster_post_inc got=%h exp=2e", v); end
  endtask

  task automatic test_wrap;
    logic [7:0] v;
    frame();
    lines(1022);
    rd(4'h4, v);
    vectors++; if (v !== 8'hFF) begin errs++; $display("FAIL wrap_511_reg4 got=%h exp=ff", v); end
    rd(4'h3, v);
    vectors++; if (v !== 8'hAE) begin errs++; $display("FAIL wrap_511_reg3 got=%h exp=ae", v); end
    lines(2);
    rd(4'h4, v);
    vectors++; if (v !== 8'h00) begin errs++; $display("FAIL wrap_0_reg4 got=%h exp=00", v); end
    rd(4'h3, v);
    vectors++; if (v !== 8'h2E) begin errs++; $display("FAIL wrap_0_reg3 got=%h exp=2e", v); end
  endtask

  task automatic test_ignored;
    logic [7:0] v;
    wr(4'h4, 8'hFF);
    wr(4'h8, 8'hFF);
    vectors++; if (dout !== 8'h2E) begin errs++; $display("FAIL ign_dout_hold got=%h exp=2e", dout); end
    rd(4'h4, v);
    vectors++; if (v !== 8'h00) begin errs++; $display("FAIL ign_reg4 got=%h exp=00", v); end
    rd(4'h3, v);
    vectors++; if (v !== 8'h2E) begin errs++; $display("FAIL ign_reg3 got=%h exp=2e", v); end
    rd(4'h8, v);
    vectors++; if (v !== 8'h5A) begin errs++; $display("FAIL ign_potx got=%h exp=5a", v); end
    rd(4'h9, v);
    vectors++; if (v !== 8'hA5) begin errs++; $display("FAIL rd_poty got=%h exp=a5", v); end
    rd(4'h6, v);
    vectors++; if (v !== 8'h3C) begin errs++; $display("FAIL rd_lpx got=%h exp=3c", v); end
    rd(4'h7, v);
    vectors++; if (v !== 8'hC3) begin errs++; $display("FAIL rd_lpy got=%h exp=c3", v); end
    rd(4'h0, v);
    vectors++; if (v !== 8'h05) begin errs++; $display("FAIL ign_reg0 got=%h exp=05", v); end
    @(negedge clk); addr = 4'h9; pot_y = 8'h11;
    @(negedge clk);
    vectors++; if (dout !== 8'h05) begin errs++; $display("FAIL dout_hold got=%h exp=05", dout); end
  endtask

  task automatic test_colors;
    logic [7:0] v;
    wr(4'hF, 8'h2E);
    vectors++; if ({back_color, inverted, border_color} !== {4'd2, 1'b0, 3'd6})
      begin errs++; $display("FAIL col_2e got=%h/%b/%h exp=2/0/6", back_color, inverted, border_color); end
    wr(4'hF, 8'h26);
    vectors++; if (inverted !== 1'b1) begin errs++; $display("FAIL col_inv got=%b exp=1", inverted); end
    rd(4'hF, v);
    vectors++; if (v !== 8'h26) begin errs++; $display("FAIL col_readback got=%h exp=26", v); end
    wr(4'hE, 8'h7C);
    wr(4'h0, 8'h8A);
    wr(4'h1, 8'h33);
    wr(4'h3, 8'hFB);
    vectors++; if ({aux_color, interlace, xorigin, yorigin} !== {4'd7, 1'b1, 7'h0A, 7'h19})
      begin errs++; $display("FAIL misc_geom got=%h/%b/%h/%h exp=7/1/0a/19", aux_color, interlace, xorigin, yorigin); end
    vectors++; if ({rows, chars8x16} !== {7'h3D, 1'b1})
      begin errs++; $display("FAIL misc_rows got=%h/%b exp=3d/1", rows, chars8x16); end
    rd(4'h3, v);
    vectors++; if (v !== 8'h7B) begin errs++; $display("FAIL misc_reg3 got=%h exp=7b", v); end
    wr(4'hB, 8'hA7);
    rd(4'hB, v);
    vectors++; if (v !== 8'hA7) begin errs++; $display("FAIL misc_regb got=%h exp=a7", v); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_addr();
    test_raster();
    test_wrap();
    test_ignored();
    test_colors();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
